// File: rtl/md_iter_seq.sv
`default_nettype none
// ============================================================================
// Module   : md_iter_seq
// Function : RV32M multiply/divide sequencer. Two-cycle multiply, radix-2
//            restoring divide. Optional macro MD_ITER_EARLY_OUT_EN enables
//            the |a| < |b| early-out.
// Revision : 1.0
// ============================================================================
module md_iter_seq #(
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [2:0]           operator_i,
  input  logic [WORD_SIZE-1:0] operand_a_i,
  input  logic [WORD_SIZE-1:0] operand_b_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [WORD_SIZE-1:0] result_o,
  output logic                 busy_o
);

  localparam int CW = $clog2(WORD_SIZE);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_SIGN = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [CW-1:0]        c_cnt_last = CW'(WORD_SIZE - 1);
  localparam logic [WORD_SIZE-1:0] c_most_neg = {1'b1, {(WORD_SIZE-1){1'b0}}};
  localparam logic [WORD_SIZE-1:0] c_all_ones = {WORD_SIZE{1'b1}};

  logic [2:0]           r_state;
  logic [CW-1:0]        r_cnt;
  logic [1:0]           r_op;
  logic [WORD_SIZE-1:0] r_a;
  logic [WORD_SIZE-1:0] r_b;
  logic [WORD_SIZE-1:0] r_quot;
  logic [WORD_SIZE-1:0] r_rem;
  logic                 r_neg_q;
  logic                 r_neg_r;
  logic [WORD_SIZE-1:0] r_result;

  // Request decode, evaluated on the raw inputs for the accept edge
  logic                 w_accept;
  logic                 w_in_div;
  logic                 w_in_signed;
  logic                 w_sign_a;
  logic                 w_sign_b;
  logic [WORD_SIZE-1:0] w_abs_a;
  logic [WORD_SIZE-1:0] w_abs_b;
  logic                 w_b_zero;
  logic                 w_ovf;

  assign w_accept    = in_valid_i & (r_state == S_IDLE);
  assign w_in_div    = operator_i[2];
  assign w_in_signed = operator_i[2] & ~(operator_i[1] ^ operator_i[0]);
  assign w_sign_a    = w_in_signed & operand_a_i[WORD_SIZE-1];
  assign w_sign_b    = w_in_signed & operand_b_i[WORD_SIZE-1];
  assign w_abs_a     = w_sign_a ? (~operand_a_i + 1'b1) : operand_a_i;
  assign w_abs_b     = w_sign_b ? (~operand_b_i + 1'b1) : operand_b_i;
  assign w_b_zero    = (operand_b_i == '0);
  assign w_ovf       = w_in_signed & (operand_a_i == c_most_neg) & (operand_b_i == c_all_ones);

  // Multiply: op[0] marks a signed multiplicand (MULH/MULHSU), op==01 a signed multiplier
  logic [2*WORD_SIZE-1:0] w_mul_a_ext;
  logic [2*WORD_SIZE-1:0] w_mul_b_ext;
  logic [2*WORD_SIZE-1:0] w_product;
  logic [WORD_SIZE-1:0]   w_mul_res;

  assign w_mul_a_ext = {{WORD_SIZE{r_op[0] & r_a[WORD_SIZE-1]}}, r_a};
  assign w_mul_b_ext = {{WORD_SIZE{(r_op == 2'b01) & r_b[WORD_SIZE-1]}}, r_b};
  assign w_product   = w_mul_a_ext * w_mul_b_ext;
  assign w_mul_res   = (r_op == 2'b00) ? w_product[WORD_SIZE-1:0]
                                       : w_product[2*WORD_SIZE-1:WORD_SIZE];

  // Restoring step: shift the next dividend bit into the partial remainder
  logic [WORD_SIZE:0]   w_shift;
  logic [WORD_SIZE:0]   w_trial;
  logic                 w_fits;
  logic [WORD_SIZE-1:0] w_quot_fix;
  logic [WORD_SIZE-1:0] w_rem_fix;
  logic [WORD_SIZE-1:0] w_div_res;

  assign w_shift    = {r_rem, r_quot[WORD_SIZE-1]};
  assign w_trial    = w_shift - {1'b0, r_b};
  assign w_fits     = ~w_trial[WORD_SIZE];
  assign w_quot_fix = r_neg_q ? (~r_quot + 1'b1) : r_quot;
  assign w_rem_fix  = r_neg_r ? (~r_rem + 1'b1) : r_rem;
  assign w_div_res  = r_op[0] ? w_rem_fix : w_quot_fix;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_quot   <= '0;
      r_rem    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
    end else if (flush_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op    <= operator_i[1:0];
            r_a     <= operand_a_i;
            r_cnt   <= '0;
            r_neg_q <= w_sign_a ^ w_sign_b;
            r_neg_r <= w_sign_a;
            if (!w_in_div) begin
              r_b     <= operand_b_i;
              r_state <= S_MUL;
            end else if (w_b_zero) begin
              r_result <= operator_i[0] ? operand_a_i : c_all_ones;
              r_state  <= S_DONE;
            end else if (w_ovf) begin
              r_result <= operator_i[0] ? '0 : operand_a_i;
              r_state  <= S_DONE;
            end else begin
              r_b <= w_abs_b;
`ifdef MD_ITER_EARLY_OUT_EN
              if (w_abs_a < w_abs_b) begin
                r_quot  <= '0;
                r_rem   <= w_abs_a;
                r_state <= S_SIGN;
              end else begin
                r_quot  <= w_abs_a;
                r_rem   <= '0;
                r_state <= S_DIV;
              end
`else
              r_quot  <= w_abs_a;
              r_rem   <= '0;
              r_state <= S_DIV;
`endif
            end
          end
        end
        S_MUL: begin
          r_result <= w_mul_res;
          r_state  <= S_DONE;
        end
        S_DIV: begin
          r_quot <= {r_quot[WORD_SIZE-2:0], w_fits};
          r_rem  <= w_fits ? w_trial[WORD_SIZE-1:0] : w_shift[WORD_SIZE-1:0];
          if (r_cnt == c_cnt_last) begin
            r_cnt   <= '0;
            r_state <= S_SIGN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_SIGN: begin
          r_result <= w_div_res;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          if (out_ready_i) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready_o  = (r_state == S_IDLE);
  assign out_valid_o = (r_state == S_DONE);
  assign busy_o      = (r_state != S_IDLE);
  assign result_o    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_md_iter_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_md_iter_seq
// Function : Directed self-checking bench for md_iter_seq (WORD_SIZE=32).
// Revision : 1.0
// ============================================================================
module tb_md_iter_seq;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        flush_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [2:0]  operator_i = 3'd0;
  logic [31:0] operand_a_i = '0;
  logic [31:0] operand_b_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] result_o;
  logic        busy_o;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHU = 3'b010, OP_MULHSU = 3'b011;
  localparam logic [2:0] OP_DIV = 3'b100, OP_REMU = 3'b101, OP_DIVU = 3'b110, OP_REM = 3'b111;

  md_iter_seq #(.WORD_SIZE(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .operator_i(operator_i), .operand_a_i(operand_a_i), .operand_b_i(operand_b_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .result_o(result_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Issues one request; lat counts edges after the accept edge until out_valid_o
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output bit ok);
    @(negedge clk_i);
    operator_i = op; operand_a_i = a; operand_b_i = b; in_valid_i = 1'b1;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0; operator_i = ~op; operand_a_i = ~a; operand_b_i = ~b;
    lat = 0;
    while (!out_valid_o && lat < 100) begin
      @(posedge clk_i); #1;
      lat++;
    end
    ok  = out_valid_o;
    res = result_o;
  endtask

  task automatic retire();
    @(negedge clk_i);
    out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    out_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++;
    if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0 || result_o !== 32'h0 || busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset: rdy=%b vld=%b res=%h busy=%b, want 1 0 00000000 0",
               in_ready_o, out_valid_o, result_o, busy_o);
    end
  endtask

  task automatic test_mul();
    logic [2:0]  ops [5] = '{OP_MULH, OP_MULHU, OP_MUL, OP_MULHSU, OP_MULHSU};
    logic [31:0] as  [5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000002};
    logic [31:0] bs  [5] = '{32'h2, 32'h2, 32'h2, 32'h2, 32'hFFFFFFFF};
    logic [31:0] exp [5] = '{32'hFFFFFFFF, 32'h1, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h1};
    logic [31:0] res;
    int lat;
    bit ok;
    for (int i = 0; i < 5; i++) begin
      issue(ops[i], as[i], bs[i], res, lat, ok);
      n_cmp++;
      if (!ok || res !== exp[i]) begin
        n_err++;
        $display("FAIL mul[%0d]: result %h valid %b, want %h", i, res, ok, exp[i]);
      end
      n_cmp++;
      if (lat !== 1) begin
        n_err++;
        $display("FAIL mul_latency[%0d]: %0d edges, want 1", i, lat);
      end
      retire();
      n_cmp++;
      if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
        n_err++;
        $display("FAIL mul_retire[%0d]: rdy=%b vld=%b, want 1 0", i, in_ready_o, out_valid_o);
      end
    end
  endtask

  task automatic test_div();
    logic [2:0]  ops [6] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU, OP_DIV, OP_REM};
    logic [31:0] as  [6] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd7, 32'd7};
    logic [31:0] bs  [6] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFE};
    logic [31:0] exp [6] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFD, 32'd1};
    logic [31:0] res;
    int lat;
    bit ok;
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], as[i], bs[i], res, lat, ok);
      n_cmp++;
      if (!ok || res !== exp[i]) begin
        n_err++;
        $display("FAIL div[%0d]: result %h valid %b, want %h", i, res, ok, exp[i]);
      end
      n_cmp++;
      if (lat !== 33) begin
        n_err++;
        $display("FAIL div_latency[%0d]: %0d edges, want 33", i, lat);
      end
      retire();
    end
  endtask

  task automatic test_special();
    logic [2:0]  ops [5] = '{OP_DIVU, OP_REM, OP_DIV, OP_REM, OP_DIV};
    logic [31:0] as  [5] = '{32'h1234, 32'h1234, 32'h80000000, 32'h80000000, 32'h55};
    logic [31:0] bs  [5] = '{32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0};
    logic [31:0] exp [5] = '{32'hFFFFFFFF, 32'h1234, 32'h80000000, 32'h0, 32'hFFFFFFFF};
    logic [31:0] res;
    int lat;
    bit ok;
    for (int i = 0; i < 5; i++) begin
      issue(ops[i], as[i], bs[i], res, lat, ok);
      n_cmp++;
      if (!ok || res !== exp[i] || lat !== 0) begin
        n_err++;
        $display("FAIL special[%0d]: result %h after %0d edges, want %h after 0", i, res, lat, exp[i]);
      end
      retire();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] res;
    int lat;
    bit ok;
    issue(OP_DIVU, 32'd100, 32'd7, res, lat, ok);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      in_valid_i = (c % 2 == 0); operator_i = OP_MUL; operand_a_i = 32'd5; operand_b_i = 32'd5;
      @(posedge clk_i); #1;
      n_cmp++;
      if (result_o !== 32'd14 || out_valid_o !== 1'b1 || in_ready_o !== 1'b0) begin
        n_err++;
        $display("FAIL backpressure[%0d]: res=%h vld=%b rdy=%b, want 0000000e 1 0",
                 c, result_o, out_valid_o, in_ready_o);
      end
    end
    in_valid_i = 1'b0;
    retire();
    @(posedge clk_i); #1;
    n_cmp++;
    if (busy_o !== 1'b0 || out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL backpressure_ignored: busy=%b vld=%b rdy=%b, want 0 0 1", busy_o, out_valid_o, in_ready_o);
    end
  endtask

  task automatic test_flush_reset();
    logic [31:0] res;
    int lat;
    bit ok;
    bit seen;
    // flush during the 10th divide iteration
    @(negedge clk_i);
    operator_i = OP_DIV; operand_a_i = 32'd1000; operand_b_i = 32'd3; in_valid_i = 1'b1;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    repeat (10) @(posedge clk_i);
    @(negedge clk_i);
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    n_cmp++;
    if (busy_o !== 1'b0 || in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL flush_div: busy=%b rdy=%b vld=%b, want 0 1 0", busy_o, in_ready_o, out_valid_o);
    end
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk_i); #1;
      if (out_valid_o) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL flush_no_valid: out_valid seen=%b, want 0", seen);
    end
    // reset asserted while in MUL
    @(negedge clk_i);
    operator_i = OP_MUL; operand_a_i = 32'd6; operand_b_i = 32'd7; in_valid_i = 1'b1;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0; rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    n_cmp++;
    if (busy_o !== 1'b0 || out_valid_o !== 1'b0 || result_o !== 32'h0) begin
      n_err++;
      $display("FAIL reset_mul: busy=%b vld=%b res=%h, want 0 0 00000000", busy_o, out_valid_o, result_o);
    end
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk_i); #1;
      if (out_valid_o) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL reset_no_valid: out_valid seen=%b, want 0", seen);
    end
    issue(OP_DIVU, 32'd9, 32'd3, res, lat, ok);
    n_cmp++;
    if (!ok || res !== 32'd3) begin
      n_err++;
      $display("FAIL after_flush_divu: result %h valid %b, want 00000003", res, ok);
    end
    // flush in DONE with handshake and new request in the same cycle: all discarded
    @(negedge clk_i);
    flush_i = 1'b1; out_ready_i = 1'b1; in_valid_i = 1'b1; operator_i = OP_MUL;
    @(posedge clk_i); #1;
    flush_i = 1'b0; out_ready_i = 1'b0; in_valid_i = 1'b0;
    n_cmp++;
    if (busy_o !== 1'b0 || out_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL flush_done_priority: busy=%b vld=%b, want 0 0", busy_o, out_valid_o);
    end
  endtask

  task automatic test_early_out();
    logic [31:0] res;
    int lat;
    bit ok;
    int exp_lat;
`ifdef MD_ITER_EARLY_OUT_EN
    exp_lat = 1;
`else
    exp_lat = 33;
`endif
    issue(OP_DIV, 32'd3, 32'd10, res, lat, ok);
    n_cmp++;
    if (!ok || res !== 32'd0 || lat !== exp_lat) begin
      n_err++;
      $display("FAIL early_div: result %h after %0d edges, want 00000000 after %0d", res, lat, exp_lat);
    end
    retire();
    issue(OP_REM, 32'hFFFFFFFD, 32'd10, res, lat, ok);
    n_cmp++;
    if (!ok || res !== 32'hFFFFFFFD || lat !== exp_lat) begin
      n_err++;
      $display("FAIL early_rem: result %h after %0d edges, want fffffffd after %0d", res, lat, exp_lat);
    end
    retire();
  endtask

  initial begin
    repeat (2) @(posedge clk_i);
    #1;
    test_reset();
    rst_i = 1'b0;
    test_mul();
    test_div();
    test_special();
    test_backpressure();
    test_flush_reset();
    test_early_out();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
